ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter. Sends one command byte (e.g. 8'hED set-LEDs,
//  8'hFF reset) to the keyboard over the same kclk/kdata pair the keyboard receiver

---
 rtl/ps2_tx_if.sv | 19 +
 rtl/ps2_host_tx.sv | 182 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_tx_if.sv
// Command handshake between a byte producer and the PS/2 host transmitter.
interface ps2_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, tx_err, err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, tx_err, err_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with open-drain pull-low enables.
// Define PS2_TX_RETRY_EN to retry a failed byte once before reporting an error.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYC = 10000,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     kclk,
  input  logic     kdata,
  output logic     kclk_oe,
  output logic     kdata_oe,
  ps2_tx_if.slave  bus
);

  localparam int unsigned CntMax = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StReq, StShift, StAck, StWaitIdle, StErr
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      idx_q, idx_d;
  logic [9:0]      frame_q, frame_d;
  logic            kdata_oe_q, kdata_oe_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            done_q, done_d;
  logic            kclk_s1, kclk_s2, kclk_prev, kdata_s1, kdata_s2;
  logic            fall, timeout, fail;
  logic [1:0]      fail_code;
`ifdef PS2_TX_RETRY_EN
  logic            retry_q, retry_d;
`endif

  assign fall    = kclk_prev & ~kclk_s2;
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYC - 1));
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kclk_s1    <= 1'b1;
      kclk_s2    <= 1'b1;
      kclk_prev  <= 1'b1;
      kdata_s1   <= 1'b1;
      kdata_s2   <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      frame_q    <= '0;
      kdata_oe_q <= 1'b0;
      err_code_q <= 2'b00;
      done_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= 1'b0;
`endif
    end else begin
      kclk_s1    <= kclk;
      kclk_s2    <= kclk_s1;
      kclk_prev  <= kclk_s2;
      kdata_s1   <= kdata;
      kdata_s2   <= kdata_s1;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      kdata_oe_q <= kdata_oe_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
`ifdef PS2_TX_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    frame_d    = frame_q;
    kdata_oe_d = kdata_oe_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    fail       = 1'b0;
    fail_code  = 2'b00;
`ifdef PS2_TX_RETRY_EN
    retry_d    = retry_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.tx_valid) begin
          // Frame word: d0..d7, odd parity, stop; start bit is driven in StReq.
          frame_d = {1'b1, ~^bus.tx_data, bus.tx_data};
          cnt_d   = '0;
          state_d = StInhibit;
`ifdef PS2_TX_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      StInhibit: begin
        cnt_d = cnt_inc;
        if (cnt_q == CntW'(INHIBIT_CYC - 1)) begin
          kdata_oe_d = 1'b1;
          state_d    = StReq;
        end
      end
      StReq: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          fail      = 1'b1;
          fail_code = 2'b01;
        end else if (fall) begin
          kdata_oe_d = ~frame_q[idx_q];
          idx_d      = idx_q + 1'b1;
          if (idx_q == 4'd9) state_d = StAck;
        end
      end
      StAck: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          fail      = 1'b1;
          fail_code = 2'b01;
        end else if (fall) begin
          if (!kdata_s2) begin
            state_d = StWaitIdle;
          end else begin
            fail      = 1'b1;
            fail_code = 2'b10;
          end
        end
      end
      StWaitIdle: begin
        cnt_d = cnt_inc;
        if (timeout) begin
          fail      = 1'b1;
          fail_code = 2'b01;
        end else if (kclk_s2 && kdata_s2) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StErr: begin
        kdata_oe_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (fail) begin
      kdata_oe_d = 1'b0;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        cnt_d   = '0;
        state_d = StInhibit;
      end else begin
        err_code_d = fail_code;
        state_d    = StErr;
      end
`else
      err_code_d = fail_code;
      state_d    = StErr;
`endif
    end
  end

  assign kclk_oe      = (state_q == StInhibit);
  assign kdata_oe     = kdata_oe_q;
  assign bus.tx_ready = (state_q == StIdle);
  assign bus.tx_done  = done_q;
  assign bus.tx_err   = (state_q == StErr);
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain keyboard model.
module tb_ps2_host_tx;
  localparam int unsigned InhCyc = 20;
  localparam int unsigned ToCyc  = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic kclk, kdata, kclk_oe, kdata_oe;
  int   checks = 0;
  int   passed = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic [10:0] bits;
  bit   ok;
  int   n;

  always #5 clk = ~clk;

  assign kclk  = !(kclk_oe || dev_clk_low);
  assign kdata = !(kdata_oe || dev_data_low);

  ps2_tx_if bus_if ();

  ps2_host_tx #(
    .INHIBIT_CYC (InhCyc),
    .TIMEOUT_CYC (ToCyc)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .kclk     (kclk),
    .kdata    (kdata),
    .kclk_oe  (kclk_oe),
    .kdata_oe (kdata_oe),
    .bus      (bus_if)
  );

  always @(negedge clk) begin
    if (bus_if.tx_done === 1'b1) done_cnt++;
    if (bus_if.tx_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus_if.tx_data  = b;
    bus_if.tx_valid = 1'b1;
    @(negedge clk);
    bus_if.tx_valid = 1'b0;
  endtask

  // Keyboard side: wait for request-to-send, clock nfalls falls, capture each bit.
  task automatic dev_frame(input int nfalls, input bit ack, output logic [10:0] got,
                           output bit good);
    int k;
    got  = '0;
    good = 1'b1;
    for (k = 0; k < InhCyc + 10 && kclk_oe !== 1'b1; k++) @(negedge clk);
    if (kclk_oe !== 1'b1) good = 1'b0;
    for (k = 0; k < InhCyc + 10 && kclk_oe !== 1'b0; k++) @(negedge clk);
    if (kclk_oe !== 1'b0) good = 1'b0;
    @(negedge clk);
    got[0] = kdata;
    for (int i = 0; i < nfalls; i++) begin
      repeat (5) @(negedge clk);
      if (i == 10 && ack) dev_data_low = 1'b1;
      repeat (3) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clk);
      if (i < 10) got[i+1] = kdata;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic wait_counts(input int want_done, input int want_err, output bit good);
    good = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done_cnt >= want_done && err_cnt >= want_err) begin
        good = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bus_if.tx_valid = 1'b0;
    bus_if.tx_data  = 8'h00;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_kclk_oe", 32'(kclk_oe), 32'd0);
    chk("rst_kdata_oe", 32'(kdata_oe), 32'd0);
    chk("rst_ready", 32'(bus_if.tx_ready), 32'd1);
    chk("rst_done", 32'(bus_if.tx_done), 32'd0);
    chk("rst_err", 32'(bus_if.tx_err), 32'd0);
    chk("rst_err_code", 32'(bus_if.err_code), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xED: d=1,0,1,1,0,1,1,1 parity 1 stop 1
    send(8'hED);
    chk("accept_kclk_low", 32'(kclk_oe), 32'd1);
    chk("busy_not_ready", 32'(bus_if.tx_ready), 32'd0);
    dev_frame(11, 1'b1, bits, ok);
    chk("ed_handshake", 32'(ok), 32'd1);
    chk("ed_frame", 32'(bits), 32'h7DA);
    wait_counts(1, 0, ok);
    chk("ed_done_seen", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    chk("ed_done_once", 32'(done_cnt), 32'd1);
    chk("ed_ready_back", 32'(bus_if.tx_ready), 32'd1);
    chk("ed_lines_free", 32'({kclk_oe, kdata_oe}), 32'd0);

    // 0xFF: parity 1
    send(8'hFF);
    dev_frame(11, 1'b1, bits, ok);
    chk("ff_frame", 32'(bits), 32'h7FE);
    wait_counts(2, 0, ok);
    repeat (3) @(negedge clk);
    chk("ff_done", 32'(done_cnt), 32'd2);

    // Device silent: timeout
    send(8'hA5);
    n = 0;
    for (int k = 0; k < 2 * (InhCyc + ToCyc) + 50; k++) begin
      @(negedge clk);
      n++;
      if (bus_if.tx_err === 1'b1) break;
    end
`ifdef PS2_TX_RETRY_EN
    chk("to_latency", 32'(n >= 2 * (InhCyc + ToCyc) && n <= 2 * (InhCyc + ToCyc) + 4), 32'd1);
`else
    chk("to_latency", 32'(n >= InhCyc + ToCyc && n <= InhCyc + ToCyc + 3), 32'd1);
`endif
    chk("to_err", 32'(bus_if.tx_err), 32'd1);
    chk("to_code", 32'(bus_if.err_code), 32'd1);
    chk("to_lines_free", 32'({kclk_oe, kdata_oe}), 32'd0);
    @(negedge clk);
    chk("to_err_pulse", 32'(bus_if.tx_err), 32'd0);
    chk("to_code_holds", 32'(bus_if.err_code), 32'd1);
    chk("to_ready", 32'(bus_if.tx_ready), 32'd1);
    chk("to_no_done", 32'(done_cnt), 32'd2);

    // No ack: 0x12 parity 1
    send(8'h12);
    dev_frame(11, 1'b0, bits, ok);
    chk("na_frame", 32'(bits), 32'h624);
`ifdef PS2_TX_RETRY_EN
    chk("na_no_err_first", 32'(err_cnt), 32'd1);
    dev_frame(11, 1'b0, bits, ok);
`endif
    wait_counts(2, 2, ok);
    repeat (3) @(negedge clk);
    chk("na_err_once", 32'(err_cnt), 32'd2);
    chk("na_code", 32'(bus_if.err_code), 32'd2);

    // Reset mid-SHIFT at idx 4, then a clean 0xF4
    send(8'h00);
    dev_frame(4, 1'b0, bits, ok);
    chk("mid_kdata_pulled", 32'(kdata_oe), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_release", 32'({kclk_oe, kdata_oe}), 32'd0);
    chk("mid_rst_ready", 32'(bus_if.tx_ready), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send(8'hF4);
    dev_frame(11, 1'b1, bits, ok);
    chk("f4_frame", 32'(bits), 32'h5E8);
    wait_counts(3, 2, ok);
    repeat (3) @(negedge clk);
    chk("f4_done", 32'(done_cnt), 32'd3);
    chk("total_err", 32'(err_cnt), 32'd2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
